// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared width limit and the carry/borrow adder used by every channel
package counter_bank_pkg;
  localparam int max_width = 64;
  function automatic logic [max_width:0] add_sub(input logic [max_width-1:0] a, input logic [max_width-1:0] b, input logic down);
    return down ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/counter_bank_channel.sv
// counter_bank_channel: one up/down counter with wrap/saturate, overflow flag and threshold-crossing pulse
module counter_bank_channel
  import counter_bank_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter bit STICKY_OVERFLOW = 1'b0,
  parameter bit SATURATE        = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] thresh_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] q_next_o,
  output logic             overflow_o,
  output logic             match_o
);
  logic [max_width:0] r;
  logic [WIDTH-1:0] cnt;
  logic cb, hit, hold, unused_hi;
  assign r = add_sub(max_width'(q_o), max_width'(step_i), down_i);
  assign cb = r[WIDTH];
  assign unused_hi = ^r[max_width:WIDTH+1];
  assign cnt = (SATURATE && cb) ? (down_i ? '0 : '1) : r[WIDTH-1:0];
  assign hit = down_i ? (q_o > thresh_i) && (cb || thresh_i >= r[WIDTH-1:0])
                      : (q_o < thresh_i) && (cb || thresh_i <= r[WIDTH-1:0]);
  assign hold = clear_i || load_i;
  assign q_next_o = clear_i ? '0 : load_i ? d_i : en_i ? cnt : q_o;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o        <= '0;
      overflow_o <= 1'b0;
      match_o    <= 1'b0;
    end else begin
      q_o        <= q_next_o;
      overflow_o <= !hold && ((en_i && cb) || (STICKY_OVERFLOW && overflow_o));
      match_o    <= !hold && en_i && hit;
    end
  end
endmodule

// File: rtl/counter_bank.sv
// counter_bank: bank of independent programmable-step counters with a shared atomic snapshot
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int NumChannels     = 4,
  parameter int WIDTH           = 16,
  parameter bit STICKY_OVERFLOW = 1'b0,
  parameter bit SATURATE        = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumChannels-1:0]       clear_i,
  input  logic [NumChannels-1:0]       en_i,
  input  logic [NumChannels-1:0]       load_i,
  input  logic [NumChannels-1:0]       down_i,
  input  logic [NumChannels*WIDTH-1:0] step_i,
  input  logic [NumChannels*WIDTH-1:0] d_i,
  input  logic [NumChannels*WIDTH-1:0] thresh_i,
  input  logic                         snap_i,
  output logic [NumChannels*WIDTH-1:0] q_o,
  output logic [NumChannels-1:0]       overflow_o,
  output logic [NumChannels-1:0]       match_o,
  output logic [NumChannels*WIDTH-1:0] snap_q_o
);
  logic [NumChannels*WIDTH-1:0] q_next;
  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    counter_bank_channel #(
      .WIDTH(WIDTH),
      .STICKY_OVERFLOW(STICKY_OVERFLOW),
      .SATURATE(SATURATE)
    ) u_ch (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .clear_i(clear_i[c]),
      .en_i(en_i[c]),
      .load_i(load_i[c]),
      .down_i(down_i[c]),
      .step_i(step_i[c*WIDTH +: WIDTH]),
      .d_i(d_i[c*WIDTH +: WIDTH]),
      .thresh_i(thresh_i[c*WIDTH +: WIDTH]),
      .q_o(q_o[c*WIDTH +: WIDTH]),
      .q_next_o(q_next[c*WIDTH +: WIDTH]),
      .overflow_o(overflow_o[c]),
      .match_o(match_o[c])
    );
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) snap_q_o <= '0;
    else if (snap_i) snap_q_o <= q_next;
  end
endmodule

// File: doc/counter_bank.md
# counter_bank

Bank of `NumChannels` independent up/down counters with programmable step, wrap-or-saturate arithmetic, sticky or pulsed overflow, a threshold-crossing event per channel, and a simultaneous snapshot of all channels. It is the multi-channel, configurable-step successor of the single `counter` and sits wherever several event or performance counters are kept side by side, e.g. a perf-counter unit behind a register file.

## Interface

Parameters:
- `NumChannels`, 4: number of independent counters (>= 1).
- `WIDTH`, 16: counter width in bits (>= 2).
- `STICKY_OVERFLOW`, 1'b0: 1 = overflow held until clear/load; 0 = one-cycle pulse.
- `SATURATE`, 1'b0: 1 = clamp at bounds; 0 = wrap modulo 2^WIDTH.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `clear_i` in NumChannels: per-channel synchronous clear.
- `en_i` in NumChannels: per-channel count enable.
- `load_i` in NumChannels: per-channel load of `d_i`.
- `down_i` in NumChannels: per-channel direction, 1 = down.
- `step_i` in NumChannels x WIDTH: per-channel step magnitude (unsigned).
- `d_i` in NumChannels x WIDTH: per-channel load value.
- `thresh_i` in NumChannels x WIDTH: per-channel threshold.
- `snap_i` in 1: capture all counters into the snapshot registers.
- `q_o` out NumChannels x WIDTH: live counter values.
- `overflow_o` out NumChannels: overflow/underflow flag.
- `match_o` out NumChannels: threshold-crossing pulse.
- `snap_q_o` out NumChannels x WIDTH: snapshot values.

## Operation

- Per channel, priority: `clear_i` > `load_i` > `en_i`. Clear sets q to 0; load sets q to `d_i`; both clear `overflow_o` and suppress `match_o`.
- Count: up computes q + step, down computes q - step, in WIDTH+1 bits; the extra bit is carry/borrow.
- Wrap mode: q takes the low WIDTH bits. Overflow is set when carry (up) or borrow (down) is 1.
- Saturate mode: on carry, q becomes all ones; on borrow, q becomes 0. Overflow is set in both cases.
- `step_i` = 0 with `en_i`: q unchanged, no overflow, no match.
- Sticky mode: `overflow_o` stays 1 until clear or load. Non-sticky mode: `overflow_o` is 1 only in the cycle after the overflowing update.
- `match_o` is 1 for one cycle after a count update that reaches or crosses `thresh_i`, evaluated in unbounded arithmetic on the pre-wrap value.
  - Up: old < thresh <= old + step.
  - Down: old > thresh >= old - step.
  - A step that overflows past the threshold region does not match on the wrapped value.
- Snapshot: when `snap_i` = 1, all `snap_q_o` capture the post-update q of the same cycle, i.e. the values `q_o` shows next cycle. Channels are mutually atomic.

## Timing

- Reset values: `q_o` = 0, `overflow_o` = 0, `match_o` = 0, `snap_q_o` = 0, all channels. Reset acts immediately and asynchronously, including mid-count.
- All outputs are registered. Latency from control inputs to `q_o`, `overflow_o`, `match_o`, `snap_q_o` is 1 cycle.
- No combinational input-to-output paths.
- Channels are fully independent. Simultaneous events on different channels never interact.
- Boundaries, wrap mode, WIDTH=4:
  - q = 15, up, step 1 gives q = 0 and overflow.
  - q = 0, down, step 3 gives q = 13 and overflow.
- Overflow set and clear in the same cycle: clear wins, flag = 0.

## Structure

- Package `counter_bank_pkg`: helper function computing `{carry, sum}` for up/down.
- Sub-module `counter_bank_channel`: one counter with its overflow and match logic. Instantiated NumChannels times via generate.
- The snapshot register array stays in the top level.

## Test plan

- Reset mid-count: channel 0 counting up at q = 7, assert `rst_i` asynchronously. All outputs are 0 before the next clock edge.
- Wrap overflow, WIDTH=4, SATURATE=0, STICKY_OVERFLOW=1: q = 14, up, step 3. Next cycle q = 1 and overflow = 1. Overflow stays 1 over 3 idle cycles, then clear gives q = 0 and overflow = 0.
- Saturate, SATURATE=1: q = 2, down, step 5. Next cycle q = 0 and overflow = 1. Non-sticky: overflow = 0 one cycle later.
- Priority: `clear_i`, `load_i` (d = 9) and `en_i` all high. Next cycle q = 0. Then `load_i` and `en_i` high: q = 9.
- Threshold, thresh = 10, q = 8, up, step 4: q = 12 and `match_o` = 1 for exactly one cycle. Next step to 16 gives no match. Step 0 gives no match.
- Snapshot: channels counting at different rates, pulse `snap_i`. `snap_q_o` equals the next-cycle `q_o` of every channel and holds while counters continue.
